// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with run-time reloadable pattern,
// fill-count progress output and a saturating match counter.
module seq_detector_param #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b0,
  parameter int                 CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in,
  input  logic                           en,
  input  logic                           pat_we,
  input  logic [SEQ_LEN-1:0]             pat_in,
  input  logic                           clr_count,
  output logic                           out,
  output logic [$clog2(SEQ_LEN+1)-1:0]   progress,
  output logic [CNT_W-1:0]               match_count
);

  localparam int             PW        = $clog2(SEQ_LEN + 1);
  localparam logic [PW-1:0]  FILL_FULL = PW'(SEQ_LEN);

  if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_len
    $error("seq_detector_param: SEQ_LEN must be in 2..16");
  end

  logic [SEQ_LEN-1:0] hist_q, hist_d;
  logic [SEQ_LEN-1:0] pat_q, pat_d;
  logic [PW-1:0]      fill_q, fill_d;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [SEQ_LEN-1:0] hist_n;
  logic [PW-1:0]      fill_n;
  logic               hit;

  always_comb begin
    hist_d = hist_q;
    pat_d  = pat_q;
    fill_d = fill_q;
    out_d  = 1'b0;
    cnt_d  = cnt_q;
    hit    = 1'b0;
    hist_n = {hist_q[SEQ_LEN-2:0], in};
    fill_n = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;

    if (pat_we) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hit    = (fill_n == FILL_FULL) && (hist_n == pat_q);
      out_d  = hit;
      hist_d = hist_n;
      // Non-overlap mode restarts the fill so the next match needs fresh bits.
      fill_d = (hit && !OVERLAP) ? '0 : fill_n;
    end

    if (clr_count) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      pat_q  <= PATTERN;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      pat_q  <= pat_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out         = out_q;
  assign progress    = fill_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: three detector variants share one stimulus stream and are
// compared against a bit-history reference model after every clock edge.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in = 1'b0;
  logic       en = 1'b0;
  logic       pat_we = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       clr_count = 1'b0;

  logic       out_a, out_b, out_c;
  logic [2:0] prog_a, prog_b, prog_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector_param u_dflt (
    .clk(clk), .rst(rst), .in(in), .en(en), .pat_we(pat_we), .pat_in(pat_in),
    .clr_count(clr_count), .out(out_a), .progress(prog_a), .match_count(cnt_a)
  );

  seq_detector_param #(.OVERLAP(1'b1)) u_ovl (
    .clk(clk), .rst(rst), .in(in), .en(en), .pat_we(pat_we), .pat_in(pat_in),
    .clr_count(clr_count), .out(out_b), .progress(prog_b), .match_count(cnt_b)
  );

  seq_detector_param #(.OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in(in), .en(en), .pat_we(pat_we), .pat_in(pat_in),
    .clr_count(clr_count), .out(out_c), .progress(prog_c), .match_count(cnt_c)
  );

  typedef struct {
    logic        out;
    int unsigned prog;
    int unsigned cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: counts valid bits since the last restart instead of a fill register.
  int unsigned m_seen [3];
  logic [3:0]  m_win  [3];
  logic [3:0]  m_pat  [3];
  int unsigned m_cnt  [3];
  logic        m_out  [3];
  bit          m_ov   [3] = '{1'b0, 1'b1, 1'b1};
  int unsigned m_cmax [3] = '{255, 255, 3};

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int i);
    logic hit;
    hit = 1'b0;
    if (rst) begin
      m_seen[i] = 0; m_win[i] = 4'b0000; m_pat[i] = 4'b1011;
      m_out[i] = 1'b0; m_cnt[i] = 0;
    end else begin
      if (pat_we) begin
        m_pat[i] = pat_in; m_seen[i] = 0; m_win[i] = 4'b0000;
      end else if (en) begin
        m_win[i]  = {m_win[i][2:0], in};
        m_seen[i] = m_seen[i] + 1;
        hit = (m_seen[i] >= 4) && (m_win[i] == m_pat[i]);
        if (hit && !m_ov[i]) m_seen[i] = 0;
      end
      m_out[i] = hit;
      if (clr_count) m_cnt[i] = 0;
      else if (hit && m_cnt[i] < m_cmax[i]) m_cnt[i] = m_cnt[i] + 1;
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [3:0] pi,
                      input logic e, input logic b, input logic c);
    exp_t x;
    rst = r; pat_we = we; pat_in = pi; en = e; in = b; clr_count = c;
    for (int i = 0; i < 3; i++) begin
      model_edge(i);
      x.out  = m_out[i];
      x.prog = (m_seen[i] > 4) ? 4 : m_seen[i];
      x.cnt  = m_cnt[i];
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      logic        g_out;
      int unsigned g_prog, g_cnt;
      logic        g_x;
      x = exp_q.pop_front();
      case (i)
        0:       begin g_out = out_a; g_prog = prog_a; g_cnt = cnt_a;
                       g_x = $isunknown({out_a, prog_a, cnt_a}); end
        1:       begin g_out = out_b; g_prog = prog_b; g_cnt = cnt_b;
                       g_x = $isunknown({out_b, prog_b, cnt_b}); end
        default: begin g_out = out_c; g_prog = prog_c; g_cnt = cnt_c;
                       g_x = $isunknown({out_c, prog_c, cnt_c}); end
      endcase
      check($sformatf("xchk%0d", i), g_x, 0);
      check($sformatf("out%0d", i), g_out, x.out);
      check($sformatf("prog%0d", i), g_prog, x.prog);
      check($sformatf("cnt%0d", i), g_cnt, x.cnt);
    end
  endtask

  task automatic bits(input logic [15:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) step(1'b0, 1'b0, 4'b0000, 1'b1, v[k], 1'b0);
  endtask

  initial begin
    logic [15:0] s;
    // Reset state.
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);

    // 1011011: one match without overlap, two with overlap.
    s = 16'b1011011;
    bits(s, 7);

    // Gap in the middle of a partial match.
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    s = 16'b10;
    bits(s, 2);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    s = 16'b11;
    bits(s, 2);

    // Pattern load discards partial progress.
    s = 16'b101;
    bits(s, 3);
    step(1'b0, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b0);
    s = 16'b0110;
    bits(s, 4);

    // Reset mid-sequence restores the default pattern.
    s = 16'b101;
    bits(s, 3);
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
    s = 16'b1011;
    bits(s, 4);

    // Back-to-back matches, counter saturation, clear winning over a hit.
    step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    s = 16'h01FF;
    bits(s, 9);
    step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
    s = 16'b11;
    bits(s, 2);
    step(1'b0, 1'b1, 4'b0101, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);

    // Random traffic with occasional loads, clears and resets.
    for (int k = 0; k < 400; k++) begin
      logic [3:0] pi;
      pi = ($urandom_range(0, 1) == 0) ? 4'b1011 : 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 24) == 0), pi,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector. Next generation of the fixed 4-bit Mealy sequence detectors in the FSM lab set.
- Pattern length, reset-default pattern and overlap mode are set by parameters. The pattern is reloadable at run time.
- Adds an input-enable qualifier, a partial-match progress output and a saturating match counter.
- Sits between a serial bit source and a controller/LED/counter stage.

Parameters:
- SEQ_LEN, 4, pattern length in bits, legal range 2..16.
- PATTERN, 4'b1011, pattern loaded at reset. Bit SEQ_LEN-1 is the first bit received.
- OVERLAP, 0, 0 = non-overlapping detection, 1 = overlapping detection.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in  input  1  serial data bit, sampled only when en=1.
- en  input  1  bit-valid qualifier.
- pat_we  input  1  pattern write strobe.
- pat_in  input  SEQ_LEN  new pattern, MSB first.
- clr_count  input  1  synchronous clear of match_count.
- out  output  1  registered one-cycle match pulse.
- progress  output  $clog2(SEQ_LEN+1)  bits accumulated toward a match (fill count).
- match_count  output  CNT_W  saturating count of matches.

Behaviour:
- Internal state:
  - hist[SEQ_LEN-1:0]: shift register of received bits.
  - fill: 0..SEQ_LEN.
  - pat: pattern register.
- Reset (rst=1 at an edge) overrides everything: hist=0, fill=0, pat=PATTERN, out=0, match_count=0. This holds mid-sequence too; partial progress is discarded.
- Priority order, highest first: rst, pat_we, en.
- pat_we=1 edge:
  - pat<=pat_in, hist<=0, fill<=0, out<=0.
  - Any in/en on that cycle is ignored.
  - match_count is unaffected unless clr_count is also asserted.
- en=1 edge, no pat_we:
  - hist_n = {hist[SEQ_LEN-2:0], in}.
  - fill_n = min(fill+1, SEQ_LEN).
  - hit = (fill_n==SEQ_LEN) && (hist_n==pat).
  - out<=hit, hist<=hist_n.
  - fill<=0 if (hit && OVERLAP==0), else fill_n.
- en=0 edge, no pat_we: hist and fill hold, out<=0. Gaps do not break a partial match.
- Latency: out goes high in the cycle after the edge that samples the last pattern bit. It is high for exactly one cycle per match; back-to-back matches give consecutive high cycles.
- OVERLAP=0: after a match, the next match needs SEQ_LEN fresh bits. Shared suffix/prefix bits do not count.
- OVERLAP=1: every window of the last SEQ_LEN valid bits that equals pat produces a match, including windows that share bits with a previous match.
- progress = fill.
  - Equals SEQ_LEN while detection is armed (window full, not cleared).
  - Equals 0 after a non-overlap match, a pattern load or a reset.
- match_count:
  - Increments by 1 on each hit edge.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_count=1 forces 0; clr_count wins over a simultaneous hit.
- No X on outputs after the first reset edge. Behaviour before the first reset is undefined.

Test Plan:
- Defaults (SEQ_LEN=4, PATTERN=1011, OVERLAP=0), en=1, in=1,0,1,1,0,1,1 -> out high only after bit 4; progress 0 after bit 4; match_count=1.
- Same stream with OVERLAP=1 -> out high after bit 4 and bit 7; match_count=2.
- Stream 1,0,(en=0 for 3 cycles),1,1 -> out pulses once, in the cycle after the final 1; out stays 0 during the gap; progress holds at 2 during the gap.
- pat_we with pat_in=0110 after bits 1,0,1, then in=0,1,1,0 -> no hit from the old partial match; out pulses after the 4th new bit.
- CNT_W=2, OVERLAP=1, 6 back-to-back matches -> match_count reaches 3 and holds. Assert clr_count on the same cycle as a hit -> match_count=0.
- rst asserted after 1,0,1 of a match, then 1,0,1,1 -> no pulse from the aborted attempt; one pulse after the new sequence; pat restored to 1011 when a different pattern was loaded before the reset.
